serial_add_sub: RTL and testbench

- Parametrised bit-serial adder/subtractor. One full-adder bit cell plus a carry flop processes WIDTH-bit operands LSB-first, one bit per clock.
- Trades latency for area against the combinational adders. Used in datapaths that are area-bound and not throughput-bound.
- Start/busy/done handshake. Result, carry-out and signed overflow are held in registers until the next accepted operation.

---
 rtl/serial_add_sub_pkg.sv | 20 ++
 rtl/full_adder.sv | 16 +
 rtl/serial_add_sub.sv | 126 ++++++++++++
 tb/tb_serial_add_sub.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_add_sub_pkg.sv
// Shared definitions for the bit-serial adder/subtractor.
package serial_add_sub_pkg;

    // Operand width limits accepted by serial_add_sub.
    localparam int unsigned MIN_WIDTH = 2;
    localparam int unsigned MAX_WIDTH = 64;

    // Controller state encoding.
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    // True when a WIDTH value can be built.
    function automatic bit width_legal(input int unsigned w);
        return (w >= MIN_WIDTH) && (w <= MAX_WIDTH);
    endfunction

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell.
module full_adder (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic S,
    output logic Cout
);

    // Sum is odd parity, carry is the majority of the three inputs.
    always_comb begin
        S    = A ^ B ^ Cin;
        Cout = (A & B) | (A & Cin) | (B & Cin);
    end

endmodule

// File: rtl/serial_add_sub.sv
// Bit-serial adder/subtractor: one full-adder cell and a carry flop process the
// operands LSB-first, one bit per clock, behind a start/busy/done handshake.
module serial_add_sub
    import serial_add_sub_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    input  logic             SUB,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             OVF,
    output logic             BUSY,
    output logic             DONE
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CntPenult = CNT_W'(WIDTH - 2);
    localparam logic [CNT_W-1:0] CntLast   = CNT_W'(WIDTH - 1);

    if (!width_legal(WIDTH)) begin : g_bad_width
        $error("serial_add_sub: WIDTH must lie in 2..64");
    end

    state_e           state_q;
    logic [WIDTH-1:0] opa_q;
    logic [WIDTH-1:0] opb_q;
    // Holds the WIDTH-1 sum bits produced so far; the last bit comes straight
    // from the cell on the final cycle.
    logic [WIDTH-2:0] sum_q;
    logic [WIDTH-1:0] sum_d;
    logic             carry_q;
    logic             cmsb_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] s_q;
    logic             cout_q;
    logic             ovf_q;
    logic             busy_q;
    logic             done_q;
    logic             fa_s;
    logic             fa_c;

    full_adder u_bit_cell (
        .A    (opa_q[0]),
        .B    (opb_q[0]),
        .Cin  (carry_q),
        .S    (fa_s),
        .Cout (fa_c)
    );

    // New sum bit enters at the MSB so the result is aligned after WIDTH shifts.
    always_comb begin
        sum_d = {fa_s, sum_q};
    end

    // Controller, datapath registers and registered handshake/result outputs.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= StIdle;
            opa_q   <= '0;
            opb_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cmsb_q  <= 1'b0;
            cnt_q   <= '0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    done_q <= 1'b0;
                    if (START) begin
                        opa_q   <= A;
                        // Subtract as A + ~B + 1.
                        opb_q   <= SUB ? ~B : B;
                        carry_q <= SUB ? 1'b1 : Cin;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= StRun;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StRun: begin
                    opa_q   <= opa_q >> 1;
                    opb_q   <= opb_q >> 1;
                    sum_q   <= sum_d[WIDTH-1:1];
                    carry_q <= fa_c;
                    cnt_q   <= cnt_q + CNT_W'(1);
                    // Carry out of bit WIDTH-2 is the carry into the MSB.
                    if (cnt_q == CntPenult) begin
                        cmsb_q <= fa_c;
                    end
                    if (cnt_q == CntLast) begin
                        s_q     <= sum_d;
                        cout_q  <= fa_c;
                        ovf_q   <= cmsb_q ^ fa_c;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= StDone;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign S    = s_q;
    assign Cout = cout_q;
    assign OVF  = ovf_q;
    assign BUSY = busy_q;
    assign DONE = done_q;

endmodule

// File: tb/tb_serial_add_sub.sv
// Directed self-checking bench for serial_add_sub at WIDTH 8, 16 and 2.
module tb_serial_add_sub;

    logic        CLK;
    logic        RST_N;
    logic        sub_r;
    logic        cin_r;

    logic        start8, start16, start2;
    logic [7:0]  a8, b8, s8;
    logic [15:0] a16, b16, s16;
    logic [1:0]  a2, b2, s2;
    logic        cout8, ovf8, busy8, done8;
    logic        cout16, ovf16, busy16, done16;
    logic        cout2, ovf2, busy2, done2;

    int vectors;
    int miscompares;

    serial_add_sub #(.WIDTH(8)) dut8 (
        .CLK(CLK), .RST_N(RST_N), .START(start8), .SUB(sub_r), .A(a8), .B(b8), .Cin(cin_r),
        .S(s8), .Cout(cout8), .OVF(ovf8), .BUSY(busy8), .DONE(done8)
    );

    serial_add_sub #(.WIDTH(16)) dut16 (
        .CLK(CLK), .RST_N(RST_N), .START(start16), .SUB(sub_r), .A(a16), .B(b16), .Cin(cin_r),
        .S(s16), .Cout(cout16), .OVF(ovf16), .BUSY(busy16), .DONE(done16)
    );

    serial_add_sub #(.WIDTH(2)) dut2 (
        .CLK(CLK), .RST_N(RST_N), .START(start2), .SUB(sub_r), .A(a2), .B(b2), .Cin(cin_r),
        .S(s2), .Cout(cout2), .OVF(ovf2), .BUSY(busy2), .DONE(done2)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Called 1 time unit after a rising edge. lat = edges from acceptance to DONE, -1 on timeout.
    task automatic run8(input logic sub, input logic [7:0] a, input logic [7:0] b,
                        input logic cin, output int lat, output int bcyc);
        sub_r = sub; cin_r = cin; a8 = a; b8 = b; start8 = 1'b1;
        @(posedge CLK); #1;
        start8 = 1'b0; lat = 0; bcyc = 0;
        while (!done8 && lat < 40) begin
            if (busy8) bcyc++;
            @(posedge CLK); #1;
            lat++;
        end
        if (!done8) lat = -1;
    endtask

    task automatic run16(input logic sub, input logic [15:0] a, input logic [15:0] b,
                         output int lat);
        sub_r = sub; cin_r = 1'b0; a16 = a; b16 = b; start16 = 1'b1;
        @(posedge CLK); #1;
        start16 = 1'b0; lat = 0;
        while (!done16 && lat < 60) begin
            @(posedge CLK); #1;
            lat++;
        end
        if (!done16) lat = -1;
    endtask

    task automatic run2(input logic sub, input logic [1:0] a, input logic [1:0] b,
                        output int lat);
        sub_r = sub; cin_r = 1'b0; a2 = a; b2 = b; start2 = 1'b1;
        @(posedge CLK); #1;
        start2 = 1'b0; lat = 0;
        while (!done2 && lat < 20) begin
            @(posedge CLK); #1;
            lat++;
        end
        if (!done2) lat = -1;
    endtask

    task automatic test_reset();
        vectors++;
        if ({s8, cout8, ovf8, busy8, done8} !== 12'h000) begin
            miscompares++;
            $display("FAIL reset8 got %h want 000", {s8, cout8, ovf8, busy8, done8});
        end
        vectors++;
        if ({s16, cout16, ovf16, busy16, done16} !== 20'h00000) begin
            miscompares++;
            $display("FAIL reset16 got %h want 00000", {s16, cout16, ovf16, busy16, done16});
        end
        vectors++;
        if ({s2, cout2, ovf2, busy2, done2} !== 6'h00) begin
            miscompares++;
            $display("FAIL reset2 got %h want 00", {s2, cout2, ovf2, busy2, done2});
        end
    endtask

    task automatic test_add();
        int lat, bc;
        run8(1'b0, 8'h5A, 8'h33, 1'b0, lat, bc);
        vectors++;
        if (lat !== 8) begin
            miscompares++; $display("FAIL add_latency got %0d want 8", lat);
        end
        vectors++;
        if (bc !== 8) begin
            miscompares++; $display("FAIL add_busy_cycles got %0d want 8", bc);
        end
        vectors++;
        if ({s8, cout8, ovf8, busy8} !== {8'h8D, 1'b0, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL add_5a_33 got S=%h C=%b V=%b B=%b want S=8d C=0 V=1 B=0",
                     s8, cout8, ovf8, busy8);
        end
        @(posedge CLK); #1;
        vectors++;
        if (done8 !== 1'b0) begin
            miscompares++; $display("FAIL done_pulse_width got %b want 0", done8);
        end
        run8(1'b0, 8'hFF, 8'h01, 1'b1, lat, bc);
        vectors++;
        if ({s8, cout8, ovf8} !== {8'h01, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL add_ff_01_cin got S=%h C=%b V=%b want S=01 C=1 V=0", s8, cout8, ovf8);
        end
    endtask

    task automatic test_sub();
        int lat, bc;
        run8(1'b1, 8'h10, 8'h20, 1'b1, lat, bc);
        vectors++;
        if ({s8, cout8, ovf8} !== {8'hF0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL sub_10_20 got S=%h C=%b V=%b want S=f0 C=0 V=0", s8, cout8, ovf8);
        end
        run8(1'b1, 8'h80, 8'h01, 1'b0, lat, bc);
        vectors++;
        if ({s8, cout8, ovf8} !== {8'h7F, 1'b1, 1'b1}) begin
            miscompares++;
            $display("FAIL sub_80_01 got S=%h C=%b V=%b want S=7f C=1 V=1", s8, cout8, ovf8);
        end
    endtask

    // START held high and operands/SUB/Cin churned during RUN must not disturb the result.
    task automatic test_handshake();
        int n;
        sub_r = 1'b0; cin_r = 1'b0; a8 = 8'h5A; b8 = 8'h33; start8 = 1'b1;
        @(posedge CLK); #1;
        n = 0;
        while (!done8 && n < 40) begin
            vectors++;
            if (s8 !== 8'h7F) begin
                miscompares++; $display("FAIL hold_during_run got %h want 7f", s8);
            end
            a8 = 8'($urandom); b8 = 8'($urandom); sub_r = ~sub_r; cin_r = ~cin_r;
            @(posedge CLK); #1;
            n++;
        end
        start8 = 1'b0;
        vectors++;
        if ({done8, s8, cout8, ovf8} !== {1'b1, 8'h8D, 1'b0, 1'b1} || n !== 8) begin
            miscompares++;
            $display("FAIL start_held got D=%b S=%h C=%b V=%b n=%0d want D=1 S=8d C=0 V=1 n=8",
                     done8, s8, cout8, ovf8, n);
        end
        @(posedge CLK); #1;
        vectors++;
        if (busy8 !== 1'b0) begin
            miscompares++; $display("FAIL idle_after_done got busy=%b want 0", busy8);
        end
    endtask

    // Second op is launched in the DONE cycle of the first: next DONE 9 edges later.
    task automatic test_back_to_back();
        int lat, bc;
        run8(1'b0, 8'h10, 8'h20, 1'b0, lat, bc);
        vectors++;
        if (s8 !== 8'h30) begin
            miscompares++; $display("FAIL b2b_first got %h want 30", s8);
        end
        run8(1'b0, 8'h01, 8'h02, 1'b0, lat, bc);
        vectors++;
        if (lat + 1 !== 9) begin
            miscompares++; $display("FAIL b2b_spacing got %0d want 9", lat + 1);
        end
        vectors++;
        if (s8 !== 8'h03) begin
            miscompares++; $display("FAIL b2b_second got %h want 03", s8);
        end
    endtask

    task automatic test_mid_reset();
        int lat, bc;
        bit saw_done;
        sub_r = 1'b0; cin_r = 1'b0; a8 = 8'h11; b8 = 8'h22; start8 = 1'b1;
        @(posedge CLK); #1;
        start8 = 1'b0;
        repeat (4) begin
            @(posedge CLK); #1;
        end
        vectors++;
        if (busy8 !== 1'b1) begin
            miscompares++; $display("FAIL midrun_busy got %b want 1", busy8);
        end
        RST_N = 1'b0;
        #1;
        vectors++;
        if ({s8, cout8, ovf8, busy8, done8} !== 12'h000) begin
            miscompares++;
            $display("FAIL abort_reset got %h want 000", {s8, cout8, ovf8, busy8, done8});
        end
        #10;
        RST_N = 1'b1;
        saw_done = 1'b0;
        repeat (12) begin
            @(posedge CLK); #1;
            if (done8) saw_done = 1'b1;
        end
        vectors++;
        if (saw_done !== 1'b0) begin
            miscompares++; $display("FAIL no_done_after_abort got %b want 0", saw_done);
        end
        run8(1'b0, 8'h7F, 8'h01, 1'b0, lat, bc);
        vectors++;
        if ({s8, cout8, ovf8} !== {8'h80, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL post_reset_op got S=%h C=%b V=%b want S=80 C=0 V=1", s8, cout8, ovf8);
        end
    endtask

    task automatic test_width16();
        int lat;
        run16(1'b0, 16'h7FFF, 16'h0001, lat);
        vectors++;
        if (lat !== 16) begin
            miscompares++; $display("FAIL w16_latency got %0d want 16", lat);
        end
        vectors++;
        if ({s16, cout16, ovf16} !== {16'h8000, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL w16_add got S=%h C=%b V=%b want S=8000 C=0 V=1", s16, cout16, ovf16);
        end
        run16(1'b1, 16'h1234, 16'h1235, lat);
        vectors++;
        if ({s16, cout16, ovf16} !== {16'hFFFF, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL w16_sub got S=%h C=%b V=%b want S=ffff C=0 V=0", s16, cout16, ovf16);
        end
    endtask

    task automatic test_width2();
        int lat;
        run2(1'b0, 2'b11, 2'b01, lat);
        vectors++;
        if (lat !== 2) begin
            miscompares++; $display("FAIL w2_latency got %0d want 2", lat);
        end
        vectors++;
        if ({s2, cout2, ovf2} !== {2'b00, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL w2_add got S=%b C=%b V=%b want S=00 C=1 V=0", s2, cout2, ovf2);
        end
        run2(1'b1, 2'b01, 2'b10, lat);
        vectors++;
        if ({s2, cout2, ovf2} !== {2'b11, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL w2_sub got S=%b C=%b V=%b want S=11 C=0 V=1", s2, cout2, ovf2);
        end
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        RST_N = 1'b0; sub_r = 1'b0; cin_r = 1'b0;
        start8 = 1'b0; start16 = 1'b0; start2 = 1'b0;
        a8 = '0; b8 = '0; a16 = '0; b16 = '0; a2 = '0; b2 = '0;
        #2;
        test_reset();
        #20;
        RST_N = 1'b1;
        @(posedge CLK); #1;
        test_reset();
        test_add();
        test_sub();
        test_handshake();
        test_back_to_back();
        test_mid_reset();
        test_width16();
        test_width2();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
